team_06_mode_ctrl: RTL

User-control sequencer for the team_06 audio path. Conditions the four push-buttons and the 2-bit quadrature volume encoder into a configuration for the datapath: transmit enable, mute, effect select, noise-gate enable and volume level. Stages every change in shadow registers and commits it only on an audio frame boundary (`frame_tick`), so the datapath never sees a mid-sample reconfiguration. Sits between the top-level pins and the ADC→effect→DAC pipeline inside team_06_top.

---
 rtl/team_06_ctrl_pkg.sv | 34 +++
 rtl/team_06_debounce.sv | 49 ++++
 rtl/team_06_mode_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/team_06_ctrl_pkg.sv
// Shared types for the team_06 user-control sequencer: commit FSM states,
// button indices and the quadrature encoder step encoding.
package team_06_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  typedef enum logic [1:0] {
    BTN_PTT    = 2'd0,
    BTN_MUTE   = 2'd1,
    BTN_EFFECT = 2'd2,
    BTN_GATE   = 2'd3
  } btn_idx_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } quad_step_e;

  // Gray sequence 00->01->11->10->00 counts up; a two-bit jump is ignored.
  function automatic quad_step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_e s;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_UP;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: s = STEP_DN;
      default:                            s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/team_06_debounce.sv
// One push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a registered one-cycle press pulse on its rising edge.
module team_06_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic hwclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) level_d = ~level_q;
      else                               cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/team_06_mode_ctrl.sv
// User-control sequencer: debounced buttons and quadrature volume stage into
// pending registers, committed to the datapath only on a frame_tick.
module team_06_mode_ctrl
  import team_06_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_EFFECTS     = 4,
  parameter int VOL_BITS        = 4,
  parameter int VOL_RESET       = 8
) (
  input  logic                hwclk,
  input  logic                reset,
  input  logic [3:0]          pbs,
  input  logic [1:0]          vol,
  input  logic                frame_tick,
  output logic                ptt_active,
  output logic                mute,
  output logic                tx_en,
  output logic [1:0]          effect_sel,
  output logic                gate_en,
  output logic [VOL_BITS-1:0] vol_level,
  output logic                cfg_update
);

  logic [3:0] btn_level, btn_press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    team_06_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .hwclk (hwclk),
      .reset (reset),
      .raw   (pbs[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  logic [1:0] vol_s1_q, vol_s2_q, vol_prev_q;
  quad_step_e step_q;

  logic                pend_ptt_q, pend_ptt_d;
  logic                pend_mute_q, pend_mute_d;
  logic [1:0]          pend_eff_q, pend_eff_d;
  logic                pend_gate_q, pend_gate_d;
  logic [VOL_BITS-1:0] pend_vol_q, pend_vol_d;

  always_comb begin
    pend_ptt_d  = btn_level[BTN_PTT];
    pend_mute_d = pend_mute_q ^ btn_press[BTN_MUTE];
    pend_gate_d = pend_gate_q ^ btn_press[BTN_GATE];
    pend_eff_d  = pend_eff_q;
    if (btn_press[BTN_EFFECT])
      pend_eff_d = (pend_eff_q == 2'(NUM_EFFECTS - 1)) ? 2'd0 : pend_eff_q + 2'd1;
    pend_vol_d = pend_vol_q;
    case (step_q)
      STEP_UP: if (pend_vol_q != '1) pend_vol_d = pend_vol_q + 1'b1;
      STEP_DN: if (pend_vol_q != '0) pend_vol_d = pend_vol_q - 1'b1;
      default: pend_vol_d = pend_vol_q;
    endcase
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      vol_s1_q    <= 2'b00;
      vol_s2_q    <= 2'b00;
      vol_prev_q  <= 2'b00;
      step_q      <= STEP_NONE;
      pend_ptt_q  <= 1'b0;
      pend_mute_q <= 1'b0;
      pend_eff_q  <= 2'd0;
      pend_gate_q <= 1'b0;
      pend_vol_q  <= VOL_BITS'(VOL_RESET);
    end else begin
      vol_s1_q    <= vol;
      vol_s2_q    <= vol_s1_q;
      vol_prev_q  <= vol_s2_q;
      step_q      <= quad_step(vol_prev_q, vol_s2_q);
      pend_ptt_q  <= pend_ptt_d;
      pend_mute_q <= pend_mute_d;
      pend_eff_q  <= pend_eff_d;
      pend_gate_q <= pend_gate_d;
      pend_vol_q  <= pend_vol_d;
    end
  end

  commit_state_e       state_q;
  logic                ptt_q, mute_q, tx_en_q, gate_q, cfg_update_q;
  logic [1:0]          eff_q;
  logic [VOL_BITS-1:0] vol_q;
  logic                cfg_diff;

  assign cfg_diff = (pend_ptt_q != ptt_q) || (pend_mute_q != mute_q) ||
                    (pend_eff_q != eff_q) || (pend_gate_q != gate_q) ||
                    (pend_vol_q != vol_q);

  // Commit samples the pending registers before this edge's updates land,
  // so a coincident event is picked up by the next frame instead.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptt_q        <= 1'b0;
      mute_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      eff_q        <= 2'd0;
      gate_q       <= 1'b0;
      vol_q        <= VOL_BITS'(VOL_RESET);
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (cfg_diff) state_q <= ST_PENDING;
        ST_PENDING: begin
          if (frame_tick) begin
            ptt_q        <= pend_ptt_q;
            mute_q       <= pend_mute_q;
            tx_en_q      <= pend_ptt_q & ~pend_mute_q;
            eff_q        <= pend_eff_q;
            gate_q       <= pend_gate_q;
            vol_q        <= pend_vol_q;
            cfg_update_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else if (!cfg_diff) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ptt_active = ptt_q;
  assign mute       = mute_q;
  assign tx_en      = tx_en_q;
  assign effect_sel = eff_q;
  assign gate_en    = gate_q;
  assign vol_level  = vol_q;
  assign cfg_update = cfg_update_q;

endmodule
